rgb_fade_sequencer: RTL and testbench



---
 rtl/rgb_pkg.sv | 33 +++
 rtl/fade_step.sv | 41 ++++
 rtl/rgb_fade_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared colour type, palette and state encoding for the RGB fade sequencer
// Purpose: common definitions imported by rgb_fade_sequencer.
// Contents: color_t ({R,G,B}, 8 bits each), state_t, PALETTE[8], next_index().
package rgb_pkg;

  typedef logic [23:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FADE   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DIMOUT = 2'd3
  } state_t;

  localparam int PALETTE_SIZE = 8;

  localparam color_t PALETTE [PALETTE_SIZE] = '{
    24'hFF0000,
    24'h00FF00,
    24'h0000FF,
    24'hFFFF00,
    24'h00FFFF,
    24'hFF00FF,
    24'hFFFFFF,
    24'hFF8000
  };

  // Palette index advance, wrapping modulo the number of colours in use.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input int num_colors);
    return (int'(idx) >= num_colors - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/fade_step.sv
// rtl/fade_step.sv - one colour channel: duty register moving one LSB toward a target per step
// Ports:
//   CLK   in   clock
//   RST   in   synchronous active-high reset (value -> 0)
//   step  in   apply one move this cycle
//   tgt   in   8-bit target value
//   value out  8-bit registered duty
//   done  out  value equals tgt once the pending move is applied
module fade_step (
  input  logic       CLK,
  input  logic       RST,
  input  logic       step,
  input  logic [7:0] tgt,
  output logic [7:0] value,
  output logic       done
);

  logic [7:0] moved;

  // Moves are always toward tgt, so value can never leave 0..255.
  always_comb begin
    moved = value;
    if (value < tgt) begin
      moved = value + 8'd1;
    end else if (value > tgt) begin
      moved = value - 8'd1;
    end
  end

  // Looks ahead at the post-step value so the FSM can leave on the completing step.
  assign done = (moved == tgt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      value <= '0;
    end else if (step) begin
      value <= moved;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - palette fader driving R/G/B PWM duties on frame boundaries
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   en         in   1 = run palette sequence, 0 = fade to black and idle
//   next_req   in   pulse: advance to the next palette colour
//   pwm_wrap   in   pulse: PWM counter rolled over (frame strobe)
//   duty_r/g/b out  8-bit channel duties
//   color_idx  out  current target palette index
//   busy       out  high while fading (FADE or DIMOUT)
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int NUM_COLORS  = 8,
  parameter int STEP_DIV    = 4,
  parameter int HOLD_FRAMES = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       next_req,
  input  logic       pwm_wrap,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic [2:0] color_idx,
  output logic       busy
);

  localparam logic [7:0]  DIV_LAST  = 8'(STEP_DIV - 1);
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_FRAMES);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [15:0] hold_cnt;

  logic        wrap_step;
  logic        hold_last;
  logic        step_en;
  logic        adv_idx;
  logic        load_hold;
  logic        hold_dec;
  color_t      tgt;
  logic        done_r;
  logic        done_g;
  logic        done_b;
  logic        all_done;

  // Every STEP_DIV-th frame is a fade step.
  assign wrap_step = pwm_wrap && (div_cnt == DIV_LAST);
  // Hold ends on the wrap that brings the counter to zero (or if already there).
  assign hold_last = pwm_wrap && (hold_cnt <= 16'd1);
  assign all_done  = done_r && done_g && done_b;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; priority is en=0, then next_req, then frame-driven events.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_FADE;
      end
      ST_FADE: begin
        if (!en) begin
          state_nxt = ST_DIMOUT;
        end else if (!next_req && wrap_step && all_done) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_nxt = ST_DIMOUT;
        end else if (next_req || hold_last) begin
          state_nxt = ST_FADE;
        end
      end
      ST_DIMOUT: begin
        if (en) begin
          state_nxt = ST_FADE;
        end else if (wrap_step && all_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    busy      = 1'b0;
    tgt       = PALETTE[color_idx];
    step_en   = 1'b0;
    adv_idx   = 1'b0;
    load_hold = 1'b0;
    hold_dec  = 1'b0;
    case (state)
      ST_FADE: begin
        busy = 1'b1;
        if (en) begin
          // A retarget on next_req takes the cycle; the old target gets no step.
          adv_idx   = next_req;
          step_en   = !next_req && wrap_step;
          load_hold = !next_req && wrap_step && all_done;
        end
      end
      ST_HOLD: begin
        if (en) begin
          // next_req and the final wrap together still advance only once.
          adv_idx  = next_req || hold_last;
          hold_dec = !next_req && pwm_wrap && (hold_cnt != 16'd0);
        end
      end
      ST_DIMOUT: begin
        busy    = 1'b1;
        tgt     = '0;
        step_en = !en && wrap_step;
      end
      default: ;
    endcase
  end

  // Palette index, hold counter and frame divider
  always_ff @(posedge CLK) begin
    if (RST) begin
      color_idx <= '0;
      hold_cnt  <= '0;
      div_cnt   <= '0;
    end else begin
      if (adv_idx) begin
        color_idx <= next_index(color_idx, NUM_COLORS);
      end

      if (load_hold) begin
        hold_cnt <= HOLD_INIT;
      end else if (hold_dec) begin
        hold_cnt <= hold_cnt - 16'd1;
      end

      // Each state starts with a full divider period before its first step.
      if (state_nxt != state) begin
        div_cnt <= '0;
      end else if (pwm_wrap) begin
        div_cnt <= wrap_step ? 8'd0 : div_cnt + 8'd1;
      end
    end
  end

  fade_step u_fade_r (
    .CLK   (CLK),
    .RST   (RST),
    .step  (step_en),
    .tgt   (tgt[23:16]),
    .value (duty_r),
    .done  (done_r)
  );

  fade_step u_fade_g (
    .CLK   (CLK),
    .RST   (RST),
    .step  (step_en),
    .tgt   (tgt[15:8]),
    .value (duty_g),
    .done  (done_g)
  );

  fade_step u_fade_b (
    .CLK   (CLK),
    .RST   (RST),
    .step  (step_en),
    .tgt   (tgt[7:0]),
    .value (duty_b),
    .done  (done_b)
  );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - directed self-checking bench for rgb_fade_sequencer
module tb_rgb_fade_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       next_req = 1'b0;
  logic       pwm_wrap = 1'b0;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [2:0] color_idx;
  logic       busy;

  logic       rst_b = 1'b1;
  logic       en_b = 1'b0;
  logic       next_b = 1'b0;
  logic       wrap_b = 1'b0;
  logic [7:0] r_b, g_b, b_b;
  logic [2:0] idx_b;
  logic       busy_b;

  int total = 0;
  int bad = 0;
  int stray = 0;

  always #5 CLK = ~CLK;

  rgb_fade_sequencer #(.NUM_COLORS(8), .STEP_DIV(1), .HOLD_FRAMES(4)) dut (
    .CLK(CLK), .RST(RST), .en(en), .next_req(next_req), .pwm_wrap(pwm_wrap),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .color_idx(color_idx), .busy(busy)
  );

  rgb_fade_sequencer #(.NUM_COLORS(3), .STEP_DIV(3), .HOLD_FRAMES(4)) dut3 (
    .CLK(CLK), .RST(rst_b), .en(en_b), .next_req(next_b), .pwm_wrap(wrap_b),
    .duty_r(r_b), .duty_g(g_b), .duty_b(b_b),
    .color_idx(idx_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One PWM frame on dut: wrap pulse, then two quiet cycles in which duties must not move.
  task automatic wrap_a(input bit with_next);
    logic [23:0] snap;
    @(negedge CLK);
    pwm_wrap = 1'b1;
    next_req = with_next;
    @(negedge CLK);
    pwm_wrap = 1'b0;
    next_req = 1'b0;
    snap = {duty_r, duty_g, duty_b};
    repeat (2) begin
      @(negedge CLK);
      if ({duty_r, duty_g, duty_b} !== snap) stray++;
    end
  endtask

  task automatic wraps_a(input int n);
    for (int i = 0; i < n; i++) wrap_a(1'b0);
  endtask

  task automatic pulse_next_a();
    @(negedge CLK);
    next_req = 1'b1;
    @(negedge CLK);
    next_req = 1'b0;
  endtask

  task automatic wrap_bt();
    @(negedge CLK);
    wrap_b = 1'b1;
    @(negedge CLK);
    wrap_b = 1'b0;
  endtask

  task automatic pulse_next_b();
    @(negedge CLK);
    next_b = 1'b1;
    @(negedge CLK);
    next_b = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    rst_b = 1'b0;
    @(negedge CLK);
    chk("rst_duties", {duty_r, duty_g, duty_b}, 24'h000000);
    chk("rst_idx", color_idx, 3'd0);
    chk("rst_busy", busy, 1'b0);

    // Fade up to red, hold, advance to green
    en = 1'b1;
    @(negedge CLK);
    chk("s1_busy", busy, 1'b1);
    chk("s1_r0", duty_r, 8'h00);
    wrap_a(1'b0);
    chk("s1_r1", {duty_r, duty_g, duty_b}, 24'h010000);
    wrap_a(1'b0);
    chk("s1_r2", {duty_r, duty_g, duty_b}, 24'h020000);
    wraps_a(253);
    chk("s1_red", {duty_r, duty_g, duty_b}, 24'hFF0000);
    chk("s1_hold", busy, 1'b0);
    wraps_a(3);
    chk("s1_hold_idx", color_idx, 3'd0);
    wrap_a(1'b0);
    chk("s1_adv_idx", color_idx, 3'd1);
    chk("s1_adv_busy", busy, 1'b1);

    // Red to green cross-fade
    wrap_a(1'b0);
    chk("s2_first", {duty_r, duty_g, duty_b}, 24'hFE0100);
    wraps_a(254);
    chk("s2_green", {duty_r, duty_g, duty_b}, 24'h00FF00);
    chk("s2_hold", busy, 1'b0);

    // next_req mid-fade, then next_req coinciding with the last hold wrap
    wraps_a(4);
    chk("s3_idx2", color_idx, 3'd2);
    wraps_a(8'h40);
    chk("s3_mid", {duty_r, duty_g, duty_b}, 24'h00BF40);
    pulse_next_a();
    chk("s3_retgt_idx", color_idx, 3'd3);
    chk("s3_no_jump", {duty_r, duty_g, duty_b}, 24'h00BF40);
    wrap_a(1'b0);
    chk("s3_retgt_step", {duty_r, duty_g, duty_b}, 24'h01C03F);
    wraps_a(254);
    chk("s3_yellow", {duty_r, duty_g, duty_b}, 24'hFFFF00);
    chk("s3_hold", busy, 1'b0);
    wraps_a(3);
    wrap_a(1'b1);
    chk("s3_single_adv", color_idx, 3'd4);
    chk("s3_fade_busy", busy, 1'b1);

    // Reach white (index 6), then dim out and come back
    wraps_a(255);
    chk("s4_cyan", {duty_r, duty_g, duty_b}, 24'h00FFFF);
    pulse_next_a();
    wraps_a(255);
    chk("s4_magenta", {duty_r, duty_g, duty_b}, 24'hFF00FF);
    pulse_next_a();
    wraps_a(255);
    chk("s4_white", {duty_r, duty_g, duty_b}, 24'hFFFFFF);
    chk("s4_white_idx", color_idx, 3'd6);
    @(negedge CLK);
    en = 1'b0;
    @(negedge CLK);
    chk("s4_dim_busy", busy, 1'b1);
    wrap_a(1'b0);
    chk("s4_dim1", {duty_r, duty_g, duty_b}, 24'hFEFEFE);
    wraps_a(254);
    chk("s4_black", {duty_r, duty_g, duty_b}, 24'h000000);
    chk("s4_idle_busy", busy, 1'b0);
    chk("s4_idle_idx", color_idx, 3'd6);
    wrap_a(1'b0);
    chk("s4_idle_stays", {duty_r, duty_g, duty_b}, 24'h000000);
    en = 1'b1;
    wraps_a(255);
    chk("s4_rewhite", {duty_r, duty_g, duty_b}, 24'hFFFFFF);
    chk("s4_rewhite_hold", busy, 1'b0);

    // Reset mid-fade at 80,7F,00
    @(negedge CLK);
    RST = 1'b1;
    en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    en = 1'b1;
    wraps_a(255);
    wraps_a(4);
    wraps_a(8'h7F);
    chk("s6_mid", {duty_r, duty_g, duty_b}, 24'h807F00);
    chk("s6_mid_idx", color_idx, 3'd1);
    @(negedge CLK);
    RST = 1'b1;
    en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("s6_rst_duties", {duty_r, duty_g, duty_b}, 24'h000000);
    chk("s6_rst_idx", color_idx, 3'd0);
    chk("s6_rst_busy", busy, 1'b0);
    wraps_a(3);
    chk("s6_quiet", {duty_r, duty_g, duty_b}, 24'h000000);
    chk("s6_quiet_busy", busy, 1'b0);

    chk("no_stray_change", stray, 0);

    // STEP_DIV=3, NUM_COLORS=3
    en_b = 1'b1;
    @(negedge CLK);
    chk("s5_busy", busy_b, 1'b1);
    wrap_bt();
    chk("s5_w1", r_b, 8'h00);
    wrap_bt();
    chk("s5_w2", r_b, 8'h00);
    wrap_bt();
    chk("s5_w3", r_b, 8'h01);
    wrap_bt();
    wrap_bt();
    chk("s5_w5", r_b, 8'h01);
    wrap_bt();
    chk("s5_w6", r_b, 8'h02);
    pulse_next_b();
    chk("s5_idx1", idx_b, 3'd1);
    pulse_next_b();
    chk("s5_idx2", idx_b, 3'd2);
    pulse_next_b();
    chk("s5_idx0", idx_b, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
